multicycle_controller: RTL and testbench

Multi-cycle MIPS control FSM that sequences the shared datapath (PC, IR, register file, single ALU, unified instruction/data memory) over several cycles per instruction. It supports the same instruction set as the single-cycle decoder: add, sub, and, or, xor, nor, slt, sll, srl, jr, jalr, addi, andi, slti, beq, bne, lw, lh, sw, sh, j, jal. Memory accesses use a req/ready handshake, so a slow memory stalls the FSM.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/mc_alu_decode.sv | 61 ++++++
 rtl/multicycle_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM:
// state enum, instruction classes, opcode/funct constants and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_R   = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_MEM_WR = 4'd9,
        S_WB_MEM = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JREG   = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        C_R       = 3'd0,
        C_I       = 3'd1,
        C_LOAD    = 3'd2,
        C_STORE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_JUMP    = 3'd5,
        C_JREG    = 3'd6,
        C_ILLEGAL = 3'd7
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_IDLE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and the
// datapath plus memory (slave).
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       branch_true;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       Jal;
    logic       Extend_h;
    logic       illegal;
    logic       retire;

    modport master (
        input  opcode, funct, branch_true, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
               ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg, Jal, Extend_h,
               illegal, retire
    );

    modport slave (
        output opcode, funct, branch_true, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
               ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg, Jal, Extend_h,
               illegal, retire
    );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational instruction decode: opcode/funct to instruction class, ALU
// operation, destination select, halfword flag, link flag and legality.
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output logic [3:0] alu_op,
    output logic       reg_dst,
    output logic       extend_h,
    output logic       link,
    output logic       legal
);

    // Decode table; anything not listed falls through as illegal.
    always_comb begin
        iclass   = C_ILLEGAL;
        alu_op   = ALU_IDLE;
        reg_dst  = 1'b0;
        extend_h = 1'b0;
        link     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                iclass  = C_R;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_JR:   iclass = C_JREG;
                    FN_JALR: begin
                        iclass = C_JREG;
                        link   = 1'b1;
                    end
                    default: iclass = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin iclass = C_I; alu_op = ALU_ADD; end
            OP_ANDI: begin iclass = C_I; alu_op = ALU_AND; end
            OP_SLTI: begin iclass = C_I; alu_op = ALU_SLT; end
            OP_LW:   begin iclass = C_LOAD; alu_op = ALU_ADD; end
            OP_LH:   begin iclass = C_LOAD; alu_op = ALU_ADD; extend_h = 1'b1; end
            OP_SW:   begin iclass = C_STORE; alu_op = ALU_ADD; end
            OP_SH:   begin iclass = C_STORE; alu_op = ALU_ADD; extend_h = 1'b1; end
            OP_BEQ:  begin iclass = C_BRANCH; alu_op = ALU_BEQ; end
            OP_BNE:  begin iclass = C_BRANCH; alu_op = ALU_BNE; end
            OP_J:    iclass = C_JUMP;
            OP_JAL:  begin iclass = C_JUMP; link = 1'b1; end
            default: iclass = C_ILLEGAL;
        endcase
        legal = (iclass != C_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM sequencing a shared PC/IR/regfile/ALU/memory
// datapath; memory accesses stall on a req/ready handshake.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  bus
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;

    iclass_e    dec_iclass_s;
    logic [3:0] dec_alu_op_s;
    logic       dec_reg_dst_s;
    logic       dec_extend_h_s;
    logic       dec_link_s;
    logic       dec_legal_s;

    logic       mem_req_s, mem_write_s, iord_s, ir_write_s, pc_write_s;
    logic [1:0] pc_source_s, alu_src_b_s;
    logic       alu_src_a_s;
    logic [3:0] alu_op_s;
    logic       reg_write_s, reg_dst_s, mem_to_reg_s, jal_s, extend_h_s;
    logic       illegal_s, retire_s;

    mc_alu_decode u_decode (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .iclass   (dec_iclass_s),
        .alu_op   (dec_alu_op_s),
        .reg_dst  (dec_reg_dst_s),
        .extend_h (dec_extend_h_s),
        .link     (dec_link_s),
        .legal    (dec_legal_s)
    );

    // Next-state and post-reset hold counter.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_FETCH;
                    hold_d  = 4'd0;
                end else begin
                    hold_d  = hold_q + 4'd1;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
                else               state_d = S_FETCH;
            end
            S_DECODE: begin
                case (dec_iclass_s)
                    C_R:      state_d = S_EXEC_R;
                    C_I:      state_d = S_EXEC_I;
                    C_LOAD:   state_d = S_ADDR;
                    C_STORE:  state_d = S_ADDR;
                    C_BRANCH: state_d = S_BRANCH;
                    C_JUMP:   state_d = S_JUMP;
                    C_JREG:   state_d = S_JREG;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_ADDR: begin
                if (dec_iclass_s == C_LOAD) state_d = S_MEM_RD;
                else                        state_d = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (bus.mem_ready) state_d = S_WB_MEM;
                else               state_d = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_d = S_FETCH;
                else               state_d = S_MEM_WR;
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JREG: state_d = S_FETCH;
            default: begin
                state_d = S_IDLE;
                hold_d  = 4'd0;
            end
        endcase
    end

    // State and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Output decode from the registered state; a reset forces IDLE and so
    // clears every strobe without waiting for a clock edge.
    always_comb begin
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_source_s  = PCSRC_ALU;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_RT;
        alu_op_s     = ALU_IDLE;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        jal_s        = 1'b0;
        extend_h_s   = 1'b0;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                alu_op_s    = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            S_DECODE: begin
                alu_src_b_s = SRCB_IMM_SH2;
                alu_op_s    = ALU_ADD;
                if (dec_legal_s) illegal_s = 1'b0;
                else             illegal_s = 1'b1;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = (state_q == S_EXEC_R) ? SRCB_RT : SRCB_IMM;
                alu_op_s    = dec_alu_op_s;
            end
            S_WB_R: begin
                reg_write_s = 1'b1;
                reg_dst_s   = dec_reg_dst_s;
                retire_s    = 1'b1;
            end
            S_WB_I: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            S_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req_s  = 1'b1;
                iord_s     = 1'b1;
                extend_h_s = dec_extend_h_s;
            end
            S_WB_MEM: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                extend_h_s   = dec_extend_h_s;
                retire_s     = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
                extend_h_s  = dec_extend_h_s;
                if (bus.mem_ready) retire_s = 1'b1;
                else               retire_s = 1'b0;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = dec_alu_op_s;
                pc_source_s = PCSRC_ALUOUT;
                pc_write_s  = bus.branch_true;
                retire_s    = 1'b1;
            end
            S_JUMP: begin
                pc_source_s = PCSRC_JUMP;
                pc_write_s  = 1'b1;
                reg_write_s = dec_link_s;
                jal_s       = dec_link_s;
                retire_s    = 1'b1;
            end
            S_JREG: begin
                pc_source_s = PCSRC_RS;
                pc_write_s  = 1'b1;
                reg_write_s = dec_link_s;
                jal_s       = dec_link_s;
                reg_dst_s   = dec_link_s;
                retire_s    = 1'b1;
            end
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    assign bus.mem_req  = mem_req_s;
    assign bus.MemWrite = mem_write_s;
    assign bus.IorD     = iord_s;
    assign bus.IRWrite  = ir_write_s;
    assign bus.PCWrite  = pc_write_s;
    assign bus.PCSource = pc_source_s;
    assign bus.ALUSrcA  = alu_src_a_s;
    assign bus.ALUSrcB  = alu_src_b_s;
    assign bus.ALUOp    = alu_op_s;
    assign bus.RegWrite = reg_write_s;
    assign bus.RegDst   = reg_dst_s;
    assign bus.MemtoReg = mem_to_reg_s;
    assign bus.Jal      = jal_s;
    assign bus.Extend_h = extend_h_s;
    assign bus.illegal  = illegal_s;
    assign bus.retire   = retire_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle control vectors, which are compared on every falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req, MemWrite, IorD, IRWrite, PCWrite;
        logic [1:0] PCSource;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [3:0] ALUOp;
        logic       RegWrite, RegDst, MemtoReg, Jal, Extend_h, illegal, retire;
    } outv_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       bt;
        logic       rdy;
        outv_t      o;
    } entry_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_J = 5, K_JR = 6, K_ILL = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller #(.RESET_HOLD(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    entry_t q[$];
    outv_t  exp_v;
    logic   exp_valid = 1'b0;
    string  cur_name = "none";
    int     cyc_idx = 0;
    int     checks = 0;
    int     failures = 0;

    function automatic outv_t blank();
        outv_t o;
        o = '0;
        return o;
    endfunction

    function automatic outv_t actual();
        outv_t o;
        o = {bus.mem_req, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSource,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.RegDst, bus.MemtoReg,
             bus.Jal, bus.Extend_h, bus.illegal, bus.retire};
        return o;
    endfunction

    task automatic check_vec(input string nm, input outv_t act, input outv_t expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle %0d: got %06h expected %06h", nm, cyc_idx, act, expv);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Instruction class straight from the ISA table.
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b100111, 6'b101010, 6'b000000, 6'b000010}) return K_R;
                if (fn == 6'b001000 || fn == 6'b001001) return K_JR;
                return K_ILL;
            end
            6'b001000, 6'b001100, 6'b001010: return K_I;
            6'b100011, 6'b100001:            return K_LD;
            6'b101011, 6'b101001:            return K_ST;
            6'b000100, 6'b000101:            return K_BR;
            6'b000010, 6'b000011:            return K_J;
            default:                         return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: return 4'b0001;
                6'b100010: return 4'b0010;
                6'b100100: return 4'b0011;
                6'b100101: return 4'b0100;
                6'b100110: return 4'b0101;
                6'b100111: return 4'b0110;
                6'b101010: return 4'b0111;
                6'b000000: return 4'b1000;
                6'b000010: return 4'b1001;
                default:   return 4'b0000;
            endcase
        end
        case (op)
            6'b001000: return 4'b0001;
            6'b001100: return 4'b0011;
            6'b001010: return 4'b0111;
            6'b000100: return 4'b1010;
            6'b000101: return 4'b1011;
            default:   return 4'b0000;
        endcase
    endfunction

    task automatic push(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic bt, input logic rdy, input outv_t o);
        entry_t e;
        e.name = nm; e.op = op; e.fn = fn; e.bt = bt; e.rdy = rdy; e.o = o;
        q.push_back(e);
    endtask

    // Expand one instruction into its cycle-by-cycle expectations.
    task automatic build(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic bt, input int fwait, input int mwait, output int n);
        outv_t o;
        int    k, start;
        logic  half, link;
        start = q.size();
        k     = classify(op, fn);
        half  = (op == 6'b100001) || (op == 6'b101001);
        link  = (op == 6'b000011) || (op == 6'b000000 && fn == 6'b001001);
        o = blank(); o.mem_req = 1'b1; o.ALUSrcB = 2'd1; o.ALUOp = 4'b0001;
        for (int i = 0; i < fwait; i++) push(nm, op, fn, bt, 1'b0, o);
        o.IRWrite = 1'b1; o.PCWrite = 1'b1;
        push(nm, op, fn, bt, 1'b1, o);
        o = blank(); o.ALUSrcB = 2'd3; o.ALUOp = 4'b0001; o.illegal = (k == K_ILL);
        push(nm, op, fn, bt, 1'b1, o);
        case (k)
            K_R, K_I: begin
                o = blank(); o.ALUSrcA = 1'b1; o.ALUSrcB = (k == K_R) ? 2'd0 : 2'd2;
                o.ALUOp = alu_code(op, fn);
                push(nm, op, fn, bt, 1'b1, o);
                o = blank(); o.RegWrite = 1'b1; o.RegDst = (k == K_R); o.retire = 1'b1;
                push(nm, op, fn, bt, 1'b1, o);
            end
            K_LD, K_ST: begin
                o = blank(); o.ALUSrcA = 1'b1; o.ALUSrcB = 2'd2; o.ALUOp = 4'b0001;
                push(nm, op, fn, bt, 1'b1, o);
                o = blank(); o.mem_req = 1'b1; o.IorD = 1'b1; o.Extend_h = half;
                o.MemWrite = (k == K_ST);
                for (int i = 0; i < mwait; i++) push(nm, op, fn, bt, 1'b0, o);
                o.retire = (k == K_ST);
                push(nm, op, fn, bt, 1'b1, o);
                if (k == K_LD) begin
                    o = blank(); o.RegWrite = 1'b1; o.MemtoReg = 1'b1; o.Extend_h = half;
                    o.retire = 1'b1;
                    push(nm, op, fn, bt, 1'b1, o);
                end
            end
            K_BR: begin
                o = blank(); o.ALUSrcA = 1'b1; o.ALUOp = alu_code(op, fn); o.PCSource = 2'd1;
                o.PCWrite = bt; o.retire = 1'b1;
                push(nm, op, fn, bt, 1'b1, o);
            end
            K_J, K_JR: begin
                o = blank(); o.PCSource = (k == K_J) ? 2'd2 : 2'd3; o.PCWrite = 1'b1;
                o.RegWrite = link; o.Jal = link; o.RegDst = link && (k == K_JR);
                o.retire = 1'b1;
                push(nm, op, fn, bt, 1'b1, o);
            end
            default: ;
        endcase
        n = q.size() - start;
    endtask

    task automatic push_idle();
        push("idle", 6'b000000, 6'b000000, 1'b0, 1'b1, blank());
    endtask

    // Drive each queued cycle; the falling-edge process does the comparison.
    task automatic play();
        entry_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            bus.opcode      = e.op;
            bus.funct       = e.fn;
            bus.branch_true = e.bt;
            bus.mem_ready   = e.rdy;
            cur_name        = e.name;
            exp_v           = e.o;
            exp_valid       = 1'b1;
            @(posedge clk);
            #1;
            cyc_idx++;
        end
        exp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_valid) check_vec(cur_name, actual(), exp_v);
    end

    initial begin
        int n;
        bus.opcode = 6'b000000; bus.funct = 6'b000000;
        bus.branch_true = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset", actual(), blank());
        @(posedge clk); #1;
        rst_n = 1'b1;

        push_idle();
        build("add", 6'b000000, 6'b100000, 1'b0, 0, 0, n);
        check_int("add_len", n, 4);
        check_int("add_aluop", int'(q[q.size()-2].o.ALUOp), 1);
        play();

        build("lw_wait3", 6'b100011, 6'b000000, 1'b0, 0, 3, n);
        check_int("lw_len", n, 8);
        build("lh_fwait2", 6'b100001, 6'b000000, 1'b0, 2, 1, n);
        check_int("lh_len", n, 8);
        build("sw", 6'b101011, 6'b000000, 1'b0, 0, 0, n);
        check_int("sw_len", n, 4);
        build("sh_wait2", 6'b101001, 6'b000000, 1'b0, 1, 2, n);
        build("addi", 6'b001000, 6'b000000, 1'b0, 0, 0, n);
        build("andi", 6'b001100, 6'b000000, 1'b0, 0, 0, n);
        build("slti", 6'b001010, 6'b000000, 1'b0, 0, 0, n);
        build("sub", 6'b000000, 6'b100010, 1'b0, 0, 0, n);
        build("and", 6'b000000, 6'b100100, 1'b0, 0, 0, n);
        build("or", 6'b000000, 6'b100101, 1'b0, 0, 0, n);
        build("xor", 6'b000000, 6'b100110, 1'b0, 0, 0, n);
        build("nor", 6'b000000, 6'b100111, 1'b0, 0, 0, n);
        build("slt", 6'b000000, 6'b101010, 1'b0, 0, 0, n);
        build("sll", 6'b000000, 6'b000000, 1'b0, 0, 0, n);
        build("srl", 6'b000000, 6'b000010, 1'b0, 0, 0, n);
        play();

        build("beq_nt", 6'b000100, 6'b000000, 1'b0, 0, 0, n);
        check_int("beq_len", n, 3);
        build("beq_t", 6'b000100, 6'b000000, 1'b1, 0, 0, n);
        check_int("beq_t_pcwrite", int'(q[q.size()-1].o.PCWrite), 1);
        build("bne_t", 6'b000101, 6'b000000, 1'b1, 0, 0, n);
        build("bne_nt", 6'b000101, 6'b000000, 1'b0, 0, 0, n);
        build("j", 6'b000010, 6'b000000, 1'b0, 0, 0, n);
        build("jal", 6'b000011, 6'b000000, 1'b0, 0, 0, n);
        check_int("jal_len", n, 3);
        build("jalr", 6'b000000, 6'b001001, 1'b0, 0, 0, n);
        build("jr", 6'b000000, 6'b001000, 1'b0, 0, 0, n);
        build("ill_op", 6'b111111, 6'b000000, 1'b0, 0, 0, n);
        check_int("ill_len", n, 2);
        build("ill_fn", 6'b000000, 6'b111111, 1'b0, 0, 0, n);
        build("add_after_ill", 6'b000000, 6'b100000, 1'b0, 0, 0, n);
        play();

        // Stall a store in MEM_WR, then pull reset mid-cycle.
        build("sw_stall", 6'b101011, 6'b000000, 1'b0, 0, 1, n);
        void'(q.pop_back());
        play();
        bus.mem_ready = 1'b0;
        #1;
        check_int("memwr_req_before_rst", int'(bus.mem_req), 1);
        check_int("memwr_we_before_rst", int'(bus.MemWrite), 1);
        rst_n = 1'b0;
        #1;
        check_vec("async_rst_outputs", actual(), blank());
        @(posedge clk); #1;
        check_vec("held_rst_outputs", actual(), blank());
        rst_n = 1'b1;
        push_idle();
        build("add_after_rst", 6'b000000, 6'b100000, 1'b0, 0, 0, n);
        play();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
